// File: rtl/cpu_mux_pkg.sv
// +-----------------------------------------------------------------------+
// | cpu_mux_pkg : shared channel count and select type for CPU muxes     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package cpu_mux_pkg;
  localparam int NCH   = 4;
  localparam int SEL_W = 2;
  typedef logic [SEL_W-1:0] sel_t;
endpackage

`default_nettype wire

// File: rtl/demux_slot.sv
// +-----------------------------------------------------------------------+
// | demux_slot : one-entry valid/ready holding register                   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module demux_slot #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RST_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // A load in the same cycle as a drain keeps the slot full with the new beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= RST_DATA;
    end else begin
      if (i_load) begin
        r_valid <= 1'b1;
        r_data  <= i_data;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/demux4x32_reg.sv
// +-----------------------------------------------------------------------+
// | demux4x32_reg : registered 1-to-4 demux with per-channel handshake    |
// | Optional drain counters built when DEMUX4X32_CNT_EN is defined.       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module demux4x32_reg
  import cpu_mux_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RST_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic [1:0]       i_sel,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_y0,
  output logic [WIDTH-1:0] o_y1,
  output logic [WIDTH-1:0] o_y2,
  output logic [WIDTH-1:0] o_y3,
  output logic             o_y0_valid,
  output logic             o_y1_valid,
  output logic             o_y2_valid,
  output logic             o_y3_valid,
  input  logic             i_y0_ready,
  input  logic             i_y1_ready,
  input  logic             i_y2_ready,
  input  logic             i_y3_ready,
  output logic [63:0]      o_cnt
);

  sel_t           w_sel;
  logic [NCH-1:0] w_valid;
  logic [NCH-1:0] w_yready;
  logic [NCH-1:0] w_load;
  logic           w_acc;

  assign w_sel    = i_sel;
  assign w_yready = {i_y3_ready, i_y2_ready, i_y1_ready, i_y0_ready};

  // Only the selected channel's consumer ready reaches o_ready combinationally.
  assign o_ready = ~rst & (~w_valid[w_sel] | w_yready[w_sel]);
  assign w_acc   = i_valid & o_ready;

  generate
    for (genvar k = 0; k < NCH; k++) begin : g_slot
      logic [WIDTH-1:0] w_data;
      logic             w_vld;

      assign w_load[k]  = w_acc & (w_sel == sel_t'(k));
      assign w_valid[k] = w_vld;

      demux_slot #(
        .WIDTH    (WIDTH),
        .RST_DATA (RST_DATA)
      ) u_slot (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load[k]),
        .i_data  (i_data),
        .i_ready (w_yready[k]),
        .o_data  (w_data),
        .o_valid (w_vld)
      );
    end
  endgenerate

  assign o_y0       = g_slot[0].w_data;
  assign o_y1       = g_slot[1].w_data;
  assign o_y2       = g_slot[2].w_data;
  assign o_y3       = g_slot[3].w_data;
  assign o_y0_valid = w_valid[0];
  assign o_y1_valid = w_valid[1];
  assign o_y2_valid = w_valid[2];
  assign o_y3_valid = w_valid[3];

`ifdef DEMUX4X32_CNT_EN
  generate
    for (genvar k = 0; k < NCH; k++) begin : g_cnt
      logic [15:0] r_cnt;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= 16'h0000;
        end else if (w_valid[k] && w_yready[k]) begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
    end
  endgenerate

  assign o_cnt = {g_cnt[3].r_cnt, g_cnt[2].r_cnt, g_cnt[1].r_cnt, g_cnt[0].r_cnt};
`else
  assign o_cnt = 64'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux4x32_reg.sv
// +-----------------------------------------------------------------------+
// | tb_demux4x32_reg : directed table, random model and counter checks   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_demux4x32_reg;

`ifdef DEMUX4X32_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_data;
  logic [1:0]  i_sel;
  logic        i_valid;
  logic [3:0]  yr;
  logic        o_ready;
  logic [31:0] y [4];
  logic [3:0]  yv;
  logic [63:0] o_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  demux4x32_reg #(.WIDTH(32), .RST_DATA(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_data     (i_data),
    .i_sel      (i_sel),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_y0       (y[0]),
    .o_y1       (y[1]),
    .o_y2       (y[2]),
    .o_y3       (y[3]),
    .o_y0_valid (yv[0]),
    .o_y1_valid (yv[1]),
    .o_y2_valid (yv[2]),
    .o_y3_valid (yv[3]),
    .i_y0_ready (yr[0]),
    .i_y1_ready (yr[1]),
    .i_y2_ready (yr[2]),
    .i_y3_ready (yr[3]),
    .o_cnt      (o_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference state: per-channel one-deep queues with a drain tally.
  bit          m_full [4];
  logic [31:0] m_data [4];
  logic [15:0] m_cnt  [4];

  function automatic logic [63:0] exp_cnt();
    if (!CNT_EN) return 64'h0;
    return {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]};
  endfunction

  // Apply the current inputs for one clock, predicting from the model.
  task automatic step_model();
    bit exp_rdy, acc;
    #2;
    exp_rdy = !rst && (!m_full[i_sel] || yr[i_sel]);
    chk("rand_ready", {63'h0, o_ready}, {63'h0, exp_rdy});
    acc = i_valid && exp_rdy;
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        m_full[k] = 0; m_data[k] = 32'h0; m_cnt[k] = 16'h0;
      end else begin
        bit drained = m_full[k] && yr[k];
        bit loaded  = acc && (int'(i_sel) == k);
        if (drained) m_cnt[k] = m_cnt[k] + 16'd1;
        if (loaded) m_data[k] = i_data;
        m_full[k] = loaded || (m_full[k] && !drained);
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rand_valid%0d", k), {63'h0, yv[k]}, {63'h0, m_full[k]});
      chk($sformatf("rand_y%0d", k), {32'h0, y[k]}, {32'h0, m_data[k]});
    end
    chk("rand_cnt", o_cnt, exp_cnt());
    return;
  endtask

  typedef struct {
    logic        rst;
    logic [31:0] d;
    logic [1:0]  s;
    logic        iv;
    logic [3:0]  yr;
    logic        exp_rdy;
    logic [3:0]  exp_v;
    int          ch;
    logic [31:0] exp_y;
    logic [63:0] exp_cnt;
  } vec_t;

  vec_t vecs [12];

  initial begin
    rst = 1'b1; i_data = '0; i_sel = '0; i_valid = 1'b0; yr = '0;

    vecs[0]  = '{1, 32'h0,        2'd0, 0, 4'b0000, 0, 4'b0000, 0, 32'h0,        64'h0};
    vecs[1]  = '{1, 32'h0,        2'd0, 0, 4'b0000, 0, 4'b0000, 3, 32'h0,        64'h0};
    vecs[2]  = '{0, 32'h0,        2'd0, 0, 4'b0000, 1, 4'b0000, 2, 32'h0,        64'h0};
    vecs[3]  = '{0, 32'hDEADBEEF, 2'd2, 1, 4'b0000, 1, 4'b0100, 2, 32'hDEADBEEF, 64'h0};
    vecs[4]  = '{0, 32'hCAFEF00D, 2'd2, 1, 4'b0000, 0, 4'b0100, 2, 32'hDEADBEEF, 64'h0};
    vecs[5]  = '{0, 32'h00000001, 2'd1, 1, 4'b0000, 1, 4'b0110, 1, 32'h00000001, 64'h0};
    vecs[6]  = '{0, 32'h11111111, 2'd0, 1, 4'b0000, 1, 4'b0111, 0, 32'h11111111, 64'h0};
    vecs[7]  = '{0, 32'hA5A5A5A5, 2'd0, 1, 4'b0001, 1, 4'b0111, 0, 32'hA5A5A5A5, 64'h1};
    vecs[8]  = '{0, 32'h0,        2'd1, 0, 4'b0010, 1, 4'b0101, 1, 32'h00000001, 64'h1_0001};
    vecs[9]  = '{0, 32'h0000FFFF, 2'd3, 0, 4'b0000, 1, 4'b0101, 3, 32'h0,        64'h1_0001};
    vecs[10] = '{0, 32'h33333333, 2'd3, 1, 4'b0000, 1, 4'b1101, 3, 32'h33333333, 64'h1_0001};
    vecs[11] = '{1, 32'h0,        2'd3, 0, 4'b1000, 0, 4'b0000, 3, 32'h0,        64'h0};

    for (int i = 0; i < 12; i++) begin
      rst = vecs[i].rst; i_data = vecs[i].d; i_sel = vecs[i].s;
      i_valid = vecs[i].iv; yr = vecs[i].yr;
      #2;
      chk($sformatf("vec%0d_ready", i), {63'h0, o_ready}, {63'h0, vecs[i].exp_rdy});
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), {60'h0, yv}, {60'h0, vecs[i].exp_v});
      chk($sformatf("vec%0d_y%0d", i, vecs[i].ch), {32'h0, y[vecs[i].ch]},
          {32'h0, vecs[i].exp_y});
      chk($sformatf("vec%0d_cnt", i), o_cnt, CNT_EN ? vecs[i].exp_cnt : 64'h0);
    end

    // Model starts from the reset state left by the last table row.
    for (int k = 0; k < 4; k++) begin
      m_full[k] = 0; m_data[k] = 32'h0; m_cnt[k] = 16'h0;
    end
    rst = 1'b0; i_valid = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      bit held;
      held = i_valid && !rst && m_full[i_sel] && !yr[i_sel];
      rst = ($urandom_range(0, 99) == 0);
      if (!held) begin
        i_data  = $urandom;
        i_sel   = 2'($urandom_range(0, 3));
        i_valid = ($urandom_range(0, 3) != 0);
      end
      yr = 4'($urandom);
      step_model();
    end

`ifdef DEMUX4X32_CNT_EN
    rst = 1'b1; i_valid = 1'b0; yr = '0;
    @(posedge clk); #1;
    rst = 1'b0; i_sel = 2'd1; i_valid = 1'b1; yr = 4'b0010;
    for (int c = 0; c < 65538; c++) begin
      i_data = c;
      @(posedge clk); #1;
    end
    chk("wrap_cnt", o_cnt, 64'h0000_0000_0001_0000);
    chk("wrap_valid1", {63'h0, yv[1]}, 64'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
